// File: rtl/pc_unit_pkg.sv
// Shared encodings for the fetch-side PC unit: NPC_* jump modes, CMP_* compare codes, FSM states.
// Optional misaligned-REG-target trap is enabled by PC_UNIT_ALIGN_CHECK_EN (see pc_unit.sv).
package pc_unit_pkg;

    localparam logic [3:0] NPC_PC4              = 4'd0;
    localparam logic [3:0] NPC_EQUAL            = 4'd1;
    localparam logic [3:0] NPC_NOT_EQUAL        = 4'd2;
    localparam logic [3:0] NPC_LARGER           = 4'd3;
    localparam logic [3:0] NPC_SMALLER          = 4'd4;
    localparam logic [3:0] NPC_LARGER_OR_EQUAL  = 4'd5;
    localparam logic [3:0] NPC_SMALLER_OR_EQUAL = 4'd6;
    localparam logic [3:0] NPC_REG              = 4'd7;
    localparam logic [3:0] NPC_J                = 4'd8;

    localparam logic [1:0] CMP_EQUAL   = 2'd0;
    localparam logic [1:0] CMP_LARGER  = 2'd1;
    localparam logic [1:0] CMP_SMALLER = 2'd2;

    typedef enum logic {
        PC_ST_RUN  = 1'b0,
        PC_ST_PEND = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_target.sv
// Combinational branch/jump decode: turns ID-stage jump fields into a taken flag and a target PC.
module pc_target
    import pc_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit BASE_PLUS4 = 1'b1
) (
    input  logic [WIDTH-1:0] id_pc,
    input  logic [3:0]       jump_mode,
    input  logic [1:0]       cmp_result,
    input  logic [15:0]      num,
    input  logic [25:0]      jnum,
    input  logic [WIDTH-1:0] reg_,
    output logic             taken,
    output logic [WIDTH-1:0] target
);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;

    // Delay-slot ISAs branch relative to the slot, not the branch itself.
    assign base      = BASE_PLUS4 ? id_pc + WIDTH'(4) : id_pc;
    assign br_target = base + {{(WIDTH-18){num[15]}}, num, 2'b00};
    assign j_target  = {base[WIDTH-1:28], jnum, 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = br_target;
        case (jump_mode)
            NPC_EQUAL:            taken = (cmp_result == CMP_EQUAL);
            NPC_NOT_EQUAL:        taken = (cmp_result != CMP_EQUAL);
            NPC_LARGER:           taken = (cmp_result == CMP_LARGER);
            NPC_SMALLER:          taken = (cmp_result == CMP_SMALLER);
            NPC_LARGER_OR_EQUAL:  taken = (cmp_result == CMP_LARGER) || (cmp_result == CMP_EQUAL);
            NPC_SMALLER_OR_EQUAL: taken = (cmp_result == CMP_SMALLER) || (cmp_result == CMP_EQUAL);
            NPC_REG: begin
                taken  = 1'b1;
                target = reg_;
            end
            NPC_J: begin
                taken  = 1'b1;
                target = j_target;
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with stall-aware redirect latching, exception entry and ERET return.
// Define PC_UNIT_ALIGN_CHECK_EN to trap misaligned register-jump targets to EXC_VECTOR.
//
//   state      | meaning
//   PC_ST_RUN  | normal fetch; pc advances or redirects when not stalled
//   PC_ST_PEND | taken redirect seen under stall; target held until stall drops
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
    parameter bit               BASE_PLUS4 = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [3:0]       jump_mode,
    input  logic [1:0]       cmp_result,
    input  logic [15:0]      num,
    input  logic [25:0]      jnum,
    input  logic [WIDTH-1:0] reg_,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic             redirect,
    output logic             pending,
    output logic             addr_exc
);

    pc_state_e        state, state_nx;
    logic [WIDTH-1:0] pc_nx;
    logic             redirect_nx;
    logic [WIDTH-1:0] pend_target, pend_target_nx;
    logic             dec_taken;
    logic [WIDTH-1:0] dec_target;
    logic             take;

    pc_target #(.WIDTH(WIDTH), .BASE_PLUS4(BASE_PLUS4)) u_target (
        .id_pc      (id_pc),
        .jump_mode  (jump_mode),
        .cmp_result (cmp_result),
        .num        (num),
        .jnum       (jnum),
        .reg_       (reg_),
        .taken      (dec_taken),
        .target     (dec_target)
    );

    assign take    = id_valid && dec_taken;
    assign pending = (state == PC_ST_PEND);

`ifdef PC_UNIT_ALIGN_CHECK_EN
    logic misalign;
    logic pend_mis, pend_mis_nx;
    logic addr_exc_q, addr_exc_nx;

    assign misalign = (jump_mode == NPC_REG) && (reg_[1:0] != 2'b00);
    assign addr_exc = addr_exc_q;
`else
    assign addr_exc = 1'b0;
`endif

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        redirect_nx    = 1'b0;
        pend_target_nx = pend_target;
`ifdef PC_UNIT_ALIGN_CHECK_EN
        pend_mis_nx    = pend_mis;
        addr_exc_nx    = 1'b0;
`endif
        if (exc_req) begin
            pc_nx       = EXC_VECTOR;
            redirect_nx = 1'b1;
            state_nx    = PC_ST_RUN;
        end else if (eret_req) begin
            pc_nx       = epc;
            redirect_nx = 1'b1;
            state_nx    = PC_ST_RUN;
        end else if (state == PC_ST_PEND) begin
            // ID is frozen while pending, so fresh decode results are ignored.
            if (!stall) begin
                pc_nx       = pend_target;
                redirect_nx = 1'b1;
                state_nx    = PC_ST_RUN;
`ifdef PC_UNIT_ALIGN_CHECK_EN
                if (pend_mis) begin
                    pc_nx       = EXC_VECTOR;
                    addr_exc_nx = 1'b1;
                end
`endif
            end
        end else if (take) begin
            if (stall) begin
                pend_target_nx = dec_target;
                state_nx       = PC_ST_PEND;
`ifdef PC_UNIT_ALIGN_CHECK_EN
                pend_mis_nx    = misalign;
`endif
            end else begin
                pc_nx       = dec_target;
                redirect_nx = 1'b1;
`ifdef PC_UNIT_ALIGN_CHECK_EN
                if (misalign) begin
                    pc_nx       = EXC_VECTOR;
                    addr_exc_nx = 1'b1;
                end
`endif
            end
        end else if (!stall) begin
            pc_nx = pc + WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PC_ST_RUN;
            pc          <= RESET_PC;
            redirect    <= 1'b0;
            pend_target <= '0;
`ifdef PC_UNIT_ALIGN_CHECK_EN
            pend_mis    <= 1'b0;
            addr_exc_q  <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            redirect    <= redirect_nx;
            pend_target <= pend_target_nx;
`ifdef PC_UNIT_ALIGN_CHECK_EN
            pend_mis    <= pend_mis_nx;
            addr_exc_q  <= addr_exc_nx;
`endif
        end
    end

endmodule
